// File: rtl/skew_pkg.sv
// Shared types and helpers for the systolic-array skew buffer.
// Lane delay depends on the lane index and on the current direction (skew or deskew).
package skew_pkg;

  typedef enum logic {
    SKEW   = 1'b0,
    DESKEW = 1'b1
  } mode_e;

  // Delay in enabled cycles seen by a given lane; deskew mirrors the skew diagonal
  function automatic int lane_depth(input mode_e m, input int lane, input int base, input int dim);
    if (m == SKEW) begin
      return base + lane;
    end
    return base + (dim - 1 - lane);
  endfunction

endpackage

// File: rtl/skew_lane.sv
// One lane of the skew buffer: a shift line of {valid, data} stages with a movable tap.
// The output is zero whenever the tapped slot holds no valid data.
module skew_lane
  import skew_pkg::*;
#(
  parameter int BITS  = 8,
  parameter int DEPTH = 9,
  parameter int TAP_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_en,
  input  logic                   i_clr,
  input  logic [TAP_W-1:0]       i_tap,
  input  logic                   i_vld,
  input  logic signed [BITS-1:0] i_d,
  output logic signed [BITS-1:0] o_q,
  output logic                   o_q_vld,
  output logic                   o_any_vld
);

  logic [DEPTH-1:0]       r_vld;
  logic signed [BITS-1:0] r_data [DEPTH];

  logic                   w_tap_vld;
  logic signed [BITS-1:0] w_tap_data;
  logic                   w_any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= '0;
      r_data <= '{default: '0};
    end else if (i_clr) begin
      r_vld  <= '0;
      r_data <= '{default: '0};
    end else if (i_en) begin
      r_vld     <= {r_vld[DEPTH-2:0], i_vld};
      r_data[0] <= i_d;
      for (int k = 1; k < DEPTH; k++) begin
        r_data[k] <= r_data[k-1];
      end
    end
  end

  // Stages past the tap are ignored both for the output and for the in-flight flag
  always_comb begin
    w_tap_vld  = 1'b0;
    w_tap_data = '0;
    w_any      = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (TAP_W'(k) == i_tap) begin
        w_tap_vld  = r_vld[k];
        w_tap_data = r_data[k];
      end
      if (TAP_W'(k) <= i_tap) begin
        w_any = w_any | r_vld[k];
      end
    end
  end

  assign o_q_vld   = w_tap_vld;
  assign o_q       = w_tap_vld ? w_tap_data : '0;
  assign o_any_vld = w_any;

endmodule

// File: rtl/skew_buf.sv
// Input/output skew buffer for the systolic array: diagonal wavefront in SKEW mode,
// realignment of the diagonal result stream in DESKEW mode, with busy/done and mode guard.
module skew_buf
  import skew_pkg::*;
#(
  parameter int BITS       = 8,
  parameter int DIM        = 8,
  parameter int BASE_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en,
  input  logic                            clr,
  input  logic                            in_vld,
  input  logic signed [DIM-1:0][BITS-1:0] din,
  input  logic                            mode_ld,
  input  logic                            mode_req,
  output logic signed [DIM-1:0][BITS-1:0] dout,
  output logic [DIM-1:0]                  dout_vld,
  output logic                            mode,
  output logic                            busy,
  output logic                            done,
  output logic                            mode_err
);

  localparam int MAX_DEPTH = BASE_DEPTH + DIM - 1;
  localparam int TAP_W     = $clog2(MAX_DEPTH);

  typedef logic signed [BITS-1:0] word_t;

  mode_e           r_mode;
  logic            r_busy_d;
  logic            r_mode_err;

  logic [DIM-1:0]  w_any;
  logic [DIM-1:0]  w_vld;
  word_t           w_q [DIM];
  logic            w_busy;
  logic            w_accept;

  for (genvar i = 0; i < DIM; i++) begin : g_lane
    logic [TAP_W-1:0] w_tap;

    assign w_tap = TAP_W'(lane_depth(r_mode, i, BASE_DEPTH, DIM) - 1);

    skew_lane #(
      .BITS  (BITS),
      .DEPTH (MAX_DEPTH),
      .TAP_W (TAP_W)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_en      (en),
      .i_clr     (clr),
      .i_tap     (w_tap),
      .i_vld     (in_vld),
      .i_d       (din[i]),
      .o_q       (w_q[i]),
      .o_q_vld   (w_vld[i]),
      .o_any_vld (w_any[i])
    );

    assign dout[i] = w_q[i];
  end

  assign w_busy   = |w_any;
  // A mode change is safe only with nothing in flight, or when this edge flushes everything
  assign w_accept = mode_ld & (~w_busy | clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode     <= SKEW;
      r_busy_d   <= 1'b0;
      r_mode_err <= 1'b0;
    end else begin
      r_busy_d   <= w_busy;
      r_mode_err <= mode_ld & ~w_accept;
      if (w_accept) begin
        r_mode <= mode_e'(mode_req);
      end
    end
  end

  assign dout_vld = w_vld;
  assign mode     = r_mode;
  assign busy     = w_busy;
  assign done     = r_busy_d & ~w_busy;
  assign mode_err = r_mode_err;

endmodule

// File: tb/tb_skew_buf.sv
// Directed bench for skew_buf (DIM=4, BITS=8, BASE_DEPTH=2) with hand-computed expectations.
module tb_skew_buf;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  en;
  logic                  clr;
  logic                  in_vld;
  logic signed [3:0][7:0] din;
  logic                  mode_ld;
  logic                  mode_req;
  logic signed [3:0][7:0] dout;
  logic [3:0]            dout_vld;
  logic                  mode;
  logic                  busy;
  logic                  done;
  logic                  mode_err;

  int total = 0;
  int bad   = 0;
  int rec [4][$];

  logic [31:0] sk_d  [7] = '{32'h0, 32'h1, 32'h200, 32'h30000, 32'h4000000, 32'h0, 32'h0};
  logic [31:0] sk_v  [7] = '{32'h0, 32'h1, 32'h2, 32'h4, 32'h8, 32'h0, 32'h0};
  logic [31:0] sk_b  [7] = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h1, 32'h0, 32'h0};
  logic [31:0] sk_dn [7] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1, 32'h0};

  skew_buf #(
    .BITS       (8),
    .DIM        (4),
    .BASE_DEPTH (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .clr      (clr),
    .in_vld   (in_vld),
    .din      (din),
    .mode_ld  (mode_ld),
    .mode_req (mode_req),
    .dout     (dout),
    .dout_vld (dout_vld),
    .mode     (mode),
    .busy     (busy),
    .done     (done),
    .mode_err (mode_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance one edge and log valid lane outputs whenever the edge was enabled
  task automatic stepr();
    logic was_en;
    was_en = en;
    step();
    if (was_en) begin
      for (int i = 0; i < 4; i++) begin
        if (dout_vld[i]) rec[i].push_back(int'(dout[i]));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; in_vld = 1'b0;
    din = '0; mode_ld = 1'b0; mode_req = 1'b0;
    #12;
    chk("rst_dout", dout, 32'h0);
    chk("rst_vld", dout_vld, 32'h0);
    chk("rst_mode", mode, 32'h0);
    chk("rst_busy", busy, 32'h0);
    chk("rst_done", done, 32'h0);
    chk("rst_err", mode_err, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // SKEW latency: single vector, lanes emerge on a diagonal
    en = 1'b1; in_vld = 1'b1; din = 32'h04030201;
    for (int e = 0; e < 7; e++) begin
      step();
      in_vld = 1'b0; din = '0;
      chk("skew_dout", dout, sk_d[e]);
      chk("skew_vld", dout_vld, sk_v[e]);
      chk("skew_busy", busy, sk_b[e]);
      chk("skew_done", done, sk_dn[e]);
    end

    // Mode guard: rejected while busy, accepted once drained
    in_vld = 1'b1; din = 32'h01010101;
    step();
    in_vld = 1'b0; din = '0; mode_ld = 1'b1; mode_req = 1'b1;
    step();
    chk("guard_mode_busy", mode, 32'h0);
    chk("guard_err_pulse", mode_err, 32'h1);
    mode_ld = 1'b0;
    step();
    chk("guard_err_clear", mode_err, 32'h0);
    step();
    step();
    step();
    chk("guard_drain_busy", busy, 32'h0);
    chk("guard_drain_done", done, 32'h1);
    mode_ld = 1'b1; mode_req = 1'b1;
    step();
    mode_ld = 1'b0;
    chk("guard_mode_acc", mode, 32'h1);
    chk("guard_err_acc", mode_err, 32'h0);

    // DESKEW realignment of a diagonal stream
    in_vld = 1'b1; din = 32'h0000000A;
    step();
    din = 32'h00001400;
    step();
    din = 32'h001E0000;
    step();
    din = 32'h28000000;
    step();
    chk("desk_pre_dout", dout, 32'h0);
    chk("desk_pre_vld", dout_vld, 32'hE);
    in_vld = 1'b0; din = '0;
    step();
    chk("desk_align_dout", dout, 32'h281E140A);
    chk("desk_align_vld", dout_vld, 32'hF);
    step();
    chk("desk_post_vld", dout_vld, 32'h7);
    step();
    step();
    step();
    chk("desk_drain_busy", busy, 32'h0);
    chk("desk_drain_done", done, 32'h1);

    // Back to SKEW, then stream 1..6 with a 3-cycle stall after the third vector
    en = 1'b0; mode_ld = 1'b1; mode_req = 1'b0;
    step();
    mode_ld = 1'b0;
    chk("stall_mode", mode, 32'h0);
    en = 1'b1; in_vld = 1'b1;
    for (int v = 1; v <= 3; v++) begin
      for (int i = 0; i < 4; i++) din[i] = 8'(v + 16 * i);
      stepr();
    end
    en = 1'b0;
    for (int i = 0; i < 4; i++) din[i] = 8'(4 + 16 * i);
    for (int s = 0; s < 3; s++) begin
      stepr();
      chk("stall_freeze_dout", dout, 32'h00001102);
      chk("stall_freeze_vld", dout_vld, 32'h3);
    end
    en = 1'b1;
    for (int v = 4; v <= 6; v++) begin
      for (int i = 0; i < 4; i++) din[i] = 8'(v + 16 * i);
      stepr();
    end
    in_vld = 1'b0; din = '0;
    for (int s = 0; s < 5; s++) stepr();
    chk("stall_end_busy", busy, 32'h0);
    chk("stall_end_done", done, 32'h1);
    for (int i = 0; i < 4; i++) begin
      chk("stall_count", rec[i].size(), 32'd6);
      for (int j = 0; j < rec[i].size() && j < 6; j++) begin
        chk("stall_value", rec[i][j], j + 1 + 16 * i);
      end
    end

    // Clear with three vectors in flight, plus a mode load that clr makes legal
    in_vld = 1'b1;
    for (int v = 0; v < 3; v++) begin
      din = 32'h05050505;
      step();
    end
    chk("clr_pre_busy", busy, 32'h1);
    clr = 1'b1; din = 32'h63636363; mode_ld = 1'b1; mode_req = 1'b1;
    step();
    chk("clr_busy", busy, 32'h0);
    chk("clr_dout", dout, 32'h0);
    chk("clr_vld", dout_vld, 32'h0);
    chk("clr_done", done, 32'h1);
    chk("clr_mode", mode, 32'h1);
    chk("clr_err", mode_err, 32'h0);
    clr = 1'b0; mode_ld = 1'b0; in_vld = 1'b0; din = '0;
    step();
    chk("clr_done_once", done, 32'h0);
    for (int s = 0; s < 5; s++) begin
      step();
      chk("clr_discard_vld", dout_vld, 32'h0);
    end

    // Asynchronous reset in DESKEW with data in flight
    in_vld = 1'b1; din = 32'h07070707;
    step();
    step();
    chk("ar_pre_vld", dout_vld, 32'h8);
    chk("ar_pre_dout", dout, 32'h07000000);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_dout", dout, 32'h0);
    chk("ar_vld", dout_vld, 32'h0);
    chk("ar_mode", mode, 32'h0);
    chk("ar_busy", busy, 32'h0);
    chk("ar_done", done, 32'h0);
    in_vld = 1'b0; din = '0;
    step();
    #1;
    rst_n = 1'b1;
    step();
    chk("ar_rel_done", done, 32'h0);
    chk("ar_rel_busy", busy, 32'h0);
    step();
    chk("ar_rel_done2", done, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
